// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin two-port front end for one registered ALU; `define ALU_ARB_ERR_EN adds rsp_err
module alu_req_arbiter #(
   parameter int DW   = 4,
   parameter int OPW  = 3,
   parameter int RW   = 8,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [OPW-1:0]  req0_op,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic [OPW-1:0]  req1_op,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [RW-1:0]   rsp_data,
   output logic [CNTW-1:0] op_count
`ifdef ALU_ARB_ERR_EN
   ,
   output logic            rsp_err
`endif
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, grant, take, id;
   logic [DW-1:0] a, b;
   logic [OPW-1:0] op;
   logic [RW-1:0] ax, bx, result;
   // grant is the winning port index; ties go to the port not served last
   assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = (state == IDLE) & req0_valid & ~grant;
   assign req1_ready = (state == IDLE) & req1_valid & grant;
   assign take       = req0_ready | req1_ready;
   assign ax         = {{(RW-DW){1'b0}}, a};
   assign bx         = {{(RW-DW){1'b0}}, b};
   always_comb begin
      result = ax + bx;
      case (op)
         OPW'(1): result = ax - bx;
         OPW'(2): result = (b == '0) ? '1 : ax / bx;
         OPW'(3): result = ax * bx;
         OPW'(4): result = ax & bx;
         OPW'(5): result = ax | bx;
         default: result = ax + bx;
      endcase
   end
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = take ? EXEC : IDLE;
         EXEC:    state_nx = RESP;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         a          <= '0;
         b          <= '0;
         op         <= '0;
         id         <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         op_count   <= '0;
`ifdef ALU_ARB_ERR_EN
         rsp_err    <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (take) begin
            a          <= grant ? req1_a : req0_a;
            b          <= grant ? req1_b : req0_b;
            op         <= grant ? req1_op : req0_op;
            id         <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_data  <= result;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
`ifdef ALU_ARB_ERR_EN
            rsp_err   <= ((op == OPW'(2)) && (b == '0)) || (op >= OPW'(6));
`endif
         end
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and random transactions against an arithmetic reference model
module tb_alu_req_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
   logic req0_ready, req1_ready, rsp_valid, rsp_id;
   logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [7:0] rsp_data, op_count;
`ifdef ALU_ARB_ERR_EN
   logic rsp_err;
`endif
   int total = 0, bad = 0, last = 1, cnt = 0;

   alu_req_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .op_count(op_count)
`ifdef ALU_ARB_ERR_EN
      , .rsp_err(rsp_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic int model(input int a, input int b, input int op);
      case (op)
         1: return (a - b + 256) % 256;
         2: return (b == 0) ? 255 : a / b;
         3: return a * b;
         4: return a & b;
         5: return a | b;
         default: return a + b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      last = 1;
      cnt = 0;
   endtask

   // one full command/response exchange, entered and left with the DUT idle, 1ns after an edge
   task automatic transact(input bit v0, input bit v1, input int a0, input int b0, input int o0,
                           input int a1, input int b1, input int o1, input int stall);
      int w, ea, eb, eo, ed;
      w  = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      eo = w ? o1 : o0;
      ed = model(ea, eb, eo);
      req0_a = a0[3:0]; req0_b = b0[3:0]; req0_op = o0[2:0];
      req1_a = a1[3:0]; req1_b = b1[3:0]; req1_op = o1[2:0];
      req0_valid = v0;
      req1_valid = v1;
      rsp_ready = 1'b0;
      #1;
      chk("idle_ready0", req0_ready, w == 0);
      chk("idle_ready1", req1_ready, w == 1);
      @(posedge clk); #1;
      last = w;
      chk("exec_valid", rsp_valid, 0);
      chk("exec_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_id", rsp_id, w);
`ifdef ALU_ARB_ERR_EN
      chk("rsp_err", rsp_err, (eo == 2 && eb == 0) || eo >= 6);
`endif
      repeat (stall) begin
         @(posedge clk); #1;
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", rsp_data, ed);
         chk("stall_id", rsp_id, w);
         chk("stall_ready", {req0_ready, req1_ready}, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      cnt = (cnt + 1) % 256;
      rsp_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("done_valid", rsp_valid, 0);
      chk("op_count", op_count, cnt);
   endtask

   initial begin
      int n, sel;
      do_reset();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_count", op_count, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      // reset while a command is executing: it vanishes without a response
      req0_a = 4'd9; req0_b = 4'd6; req0_op = 3'd0; req0_valid = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      last = 1;
      cnt = 0;
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_count", op_count, 0);
      repeat (3) @(posedge clk);
      #1 chk("midrst_quiet", rsp_valid, 0);
      chk("midrst_data", rsp_data, 0);
      transact(1, 0, 9, 6, 0, 0, 0, 0, 0);
      transact(0, 1, 0, 0, 0, 3, 5, 1, 0);
      transact(1, 0, 7, 9, 3, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) transact(1, 1, i, 2, 4 + (i % 2), 15 - i, 3, 3, 0);
      transact(1, 0, 12, 0, 2, 0, 0, 0, 0);
      transact(0, 1, 0, 0, 0, 2, 3, 6, 0);
      transact(1, 1, 15, 15, 3, 1, 1, 7, 5);
      n = 256 - cnt;
      repeat (n) begin
         sel = $urandom_range(1, 3);
         transact(sel[0], sel[1], $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 2));
      end
      chk("wrap", op_count, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
